// File: rtl/cache_axi_burst_ctrl_pkg.sv
// Shared definitions for the cache AXI burst master: FSM states, AXI encodings
// and the beat-count derivation used by the burst controller.
package cache_axi_burst_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        WLOAD,
        AW,
        W,
        B,
        DONE
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    function automatic int beats_of(input int block_width, input int data_width);
        return block_width / data_width;
    endfunction

endpackage

// File: rtl/cache_axi_burst_ctrl.sv
// AXI4 burst master for cache line refill and writeback. Owns control, address,
// beat counting and response checking; data paths are wired around it.
module cache_axi_burst_ctrl
    import cache_axi_burst_ctrl_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int BLOCK_WIDTH    = 512,
    parameter int AXI_ADDR_WIDTH = 64
) (
    input  logic                        i_clk,
    input  logic                        i_arst,
    input  logic                        i_start_read,
    input  logic                        i_start_write,
    input  logic [AXI_ADDR_WIDTH-1:0]   i_addr,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_error,
    output logic                        o_shift_en,
    output logic                        o_load_block,
    output logic                        o_ar_valid,
    input  logic                        i_ar_ready,
    output logic [AXI_ADDR_WIDTH-1:0]   o_ar_addr,
    output logic [7:0]                  o_ar_len,
    output logic [2:0]                  o_ar_size,
    output logic [1:0]                  o_ar_burst,
    input  logic                        i_r_valid,
    output logic                        o_r_ready,
    input  logic                        i_r_last,
    input  logic [1:0]                  i_r_resp,
    output logic                        o_aw_valid,
    input  logic                        i_aw_ready,
    output logic [AXI_ADDR_WIDTH-1:0]   o_aw_addr,
    output logic [7:0]                  o_aw_len,
    output logic [2:0]                  o_aw_size,
    output logic [1:0]                  o_aw_burst,
    output logic                        o_w_valid,
    input  logic                        i_w_ready,
    output logic                        o_w_last,
    output logic [AXI_DATA_WIDTH/8-1:0] o_w_strb,
    input  logic                        i_b_valid,
    output logic                        o_b_ready,
    input  logic [1:0]                  i_b_resp
);

    localparam int BEATS = beats_of(BLOCK_WIDTH, AXI_DATA_WIDTH);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_t                      state;
    state_t                      state_next;
    logic [CNT_W-1:0]            cnt;
    logic [CNT_W-1:0]            cnt_next;
    logic                        err;
    logic                        err_next;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [AXI_ADDR_WIDTH-1:0]   addr_next;

    assign o_ar_addr  = addr_q;
    assign o_aw_addr  = addr_q;
    assign o_ar_len   = 8'(BEATS - 1);
    assign o_aw_len   = 8'(BEATS - 1);
    assign o_ar_size  = 3'($clog2(AXI_DATA_WIDTH / 8));
    assign o_aw_size  = 3'($clog2(AXI_DATA_WIDTH / 8));
    assign o_ar_burst = BURST_INCR;
    assign o_aw_burst = BURST_INCR;
    assign o_w_strb   = '1;

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state  <= IDLE;
            cnt    <= '0;
            err    <= 1'b0;
            addr_q <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            err    <= err_next;
            addr_q <= addr_next;
        end
    end

    // Bursts finish on the beat count; RLAST is only checked against it.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        err_next     = err;
        addr_next    = addr_q;
        o_busy       = (state != IDLE);
        o_done       = 1'b0;
        o_error      = 1'b0;
        o_shift_en   = 1'b0;
        o_load_block = 1'b0;
        o_ar_valid   = 1'b0;
        o_r_ready    = 1'b0;
        o_aw_valid   = 1'b0;
        o_w_valid    = 1'b0;
        o_w_last     = 1'b0;
        o_b_ready    = 1'b0;
        case (state)
            IDLE: begin
                if (i_start_write) begin
                    addr_next  = i_addr;
                    state_next = WLOAD;
                end else if (i_start_read) begin
                    addr_next  = i_addr;
                    state_next = AR;
                end
            end
            AR: begin
                o_ar_valid = 1'b1;
                if (i_ar_ready) begin
                    state_next = R;
                end
            end
            R: begin
                o_r_ready = 1'b1;
                if (i_r_valid) begin
                    o_shift_en = 1'b1;
                    err_next   = err | (i_r_resp != RESP_OKAY);
                    if (cnt == LAST_BEAT) begin
                        err_next   = err | (i_r_resp != RESP_OKAY) | ~i_r_last;
                        cnt_next   = '0;
                        state_next = DONE;
                    end else begin
                        err_next = err | (i_r_resp != RESP_OKAY) | i_r_last;
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            WLOAD: begin
                o_load_block = 1'b1;
                state_next   = AW;
            end
            AW: begin
                o_aw_valid = 1'b1;
                if (i_aw_ready) begin
                    state_next = W;
                end
            end
            W: begin
                o_w_valid = 1'b1;
                o_w_last  = (cnt == LAST_BEAT);
                if (i_w_ready) begin
                    o_shift_en = 1'b1;
                    if (cnt == LAST_BEAT) begin
                        cnt_next   = '0;
                        state_next = B;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            B: begin
                o_b_ready = 1'b1;
                if (i_b_valid) begin
                    err_next   = err | (i_b_resp != RESP_OKAY);
                    state_next = DONE;
                end
            end
            DONE: begin
                o_done     = 1'b1;
                o_error    = err;
                cnt_next   = '0;
                err_next   = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/cache_axi_burst_ctrl.md
Name: cache_axi_burst_ctrl

Overview:
- AXI4 burst master FSM for cache line refill and writeback.
- Sits between the cache controller and the AXI bus, and drives the line shift register's enables.
  - Refill: each accepted R beat shifts into the line register.
  - Writeback: loads the line register, then shifts once per accepted W beat.
- Data buses are wired externally (R data into the shift register, shift register low word onto W data). This block owns only control, address, beat counting and response checking.

Parameters:
- AXI_DATA_WIDTH, 32, AXI data bus width in bits; power of two, ≥8.
- BLOCK_WIDTH, 512, cache line width in bits; integer multiple of AXI_DATA_WIDTH.
- AXI_ADDR_WIDTH, 64, address width.
- Derived: BEATS = BLOCK_WIDTH/AXI_DATA_WIDTH (≤256); CNT_W = $clog2(BEATS).

Ports:
- i_clk in 1: clock, rising edge.
- i_arst in 1: reset; synchronous, active-high.
- i_start_read in 1: request line refill.
- i_start_write in 1: request line writeback.
- i_addr in AXI_ADDR_WIDTH: line-aligned address, sampled on accepted start.
- o_busy out 1: transaction in progress.
- o_done out 1: one-cycle completion pulse.
- o_error out 1: valid with o_done; nonzero resp or RLAST mismatch.
- o_shift_en out 1: drives the shift register write enable.
- o_load_block out 1: drives the shift register parallel load.
- o_ar_valid out 1; i_ar_ready in 1; o_ar_addr out AXI_ADDR_WIDTH; o_ar_len out 8; o_ar_size out 3; o_ar_burst out 2.
- i_r_valid in 1; o_r_ready out 1; i_r_last in 1; i_r_resp in 2.
- o_aw_valid out 1; i_aw_ready in 1; o_aw_addr out AXI_ADDR_WIDTH; o_aw_len out 8; o_aw_size out 3; o_aw_burst out 2.
- o_w_valid out 1; i_w_ready in 1; o_w_last out 1; o_w_strb out AXI_DATA_WIDTH/8.
- i_b_valid in 1; o_b_ready out 1; i_b_resp in 2.

Behaviour:
- Reset: state IDLE; beat counter 0; error flag 0. All valid/ready/enable/pulse outputs 0; address registers 0.
- Constant outputs:
  - len = BEATS-1.
  - size = $clog2(AXI_DATA_WIDTH/8).
  - burst = INCR (2'b01).
  - w_strb = all ones.
- States:
  - IDLE:
    - Starts are accepted only here.
    - i_start_write has priority over i_start_read when both are high; the read is dropped and the caller must re-issue it.
    - Start on write → WLOAD. Start on read → AR. Address latched in both cases.
    - o_busy=0 only in IDLE.
  - AR: o_ar_valid=1 with the latched address; held stable until i_ar_ready → R.
  - R:
    - o_r_ready=1.
    - Each cycle with i_r_valid: o_shift_en=1 (same cycle, combinational), counter++, OR (i_r_resp≠0) into the error flag.
    - On beat BEATS-1: error |= !i_r_last → DONE.
    - i_r_last high early also sets error. The burst still completes on count, not on last.
  - WLOAD: o_load_block=1 for exactly one cycle → AW. o_shift_en is never asserted together with o_load_block.
  - AW: o_aw_valid=1 until i_aw_ready → W. W is not issued before the AW handshake.
  - W:
    - o_w_valid=1; o_w_last = (counter==BEATS-1).
    - On i_w_ready: o_shift_en=1, counter++.
    - On the last beat → B with counter cleared.
    - Shift occurs after the accept, so the next beat is on the shift register output the following cycle.
  - B: o_b_ready=1; on i_b_valid: error |= (i_b_resp≠0) → DONE.
  - DONE:
    - o_done=1 and o_error=error flag for one cycle.
    - Counter and error are cleared → IDLE.
    - A start in DONE is ignored.
- Latencies:
  - Accepted read start → o_ar_valid in the next cycle.
  - Write start → o_load_block next cycle, o_aw_valid the cycle after.
  - Zero-wait-state slave, read: start + 1 (AR) + BEATS (R) + 1 (DONE); o_done is high in cycle BEATS+2 after start.
- Counter wraps only via explicit clear; it never exceeds BEATS-1.
- A valid is never dropped before its ready (AXI stability). Address registers are stable while valid is high.
- i_arst mid-transaction:
  - Returns to IDLE the next edge with all outputs deasserted.
  - No o_done.
  - Bus-side recovery is the system reset's responsibility.

Decomposition:
- Shared cache package:
  - State enum (IDLE, AR, R, WLOAD, AW, W, B, DONE).
  - AXI constants: BURST_INCR=2'b01, RESP_OKAY=2'b00.
  - BEATS derivation helper.
- No sub-module; counter and FSM are inline.

Test Plan:
- Refill, zero-wait slave, defaults (BEATS=16):
  - Stimulus: start_read, addr 0x8000_0040; R data 0..15 with last on beat 15.
  - Response: ar_len=15, ar_size=2, burst=1; 16 o_shift_en pulses; shift register holds words 0..15 in ascending order; o_done at cycle 18, o_error=0.
- Writeback with backpressure:
  - Stimulus: start_write, line 0x0F..00 pattern; i_aw_ready delayed 3 cycles; i_w_ready toggling 1/0.
  - Response: one o_load_block; AW stable for all 3 wait cycles; 16 W beats in order with o_w_last only on beat 16; B OKAY → o_done, o_error=0.
- Error paths:
  - Refill with r_resp=SLVERR on beat 5 → o_error=1 with o_done; still exactly 16 shifts.
  - Separately, r_last asserted on beat 10 → o_error=1.
  - Writeback with b_resp=DECERR → o_error=1.
- Start contention: start_read and start_write high in the same IDLE cycle → write path taken, no AR; starts pulsed during R or W are ignored.
- Reset mid-burst: assert i_arst after beat 7 of a refill → next cycle IDLE, o_r_ready=0, no o_done; a new refill afterwards completes normally.
- Parameter sweep: AXI_DATA_WIDTH=64, BLOCK_WIDTH=512 → len=7, size=3, 8 beats, w_strb=0xFF.
